otbn_run_ctrl: RTL and testbench
================================

OTBN_RUN_CTRL -- requirements
Module: otbn_run_ctrl

Interface
REQ-001 SHALL provide parameter CntW, default 32, width of cycle counter, timeout and sample-cycle fields.
REQ-002 SHALL provide parameter AddrW, default 32, width of instruction fetch address.
REQ-003 SHALL provide parameter SampleInterval, default 1000, cycles between progress samples; legal range 1 to 2^CntW-1.
REQ-004 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port run_req_i, input, 1, request one OTBN run; sampled only in IDLE.
REQ-007 SHALL have port timeout_i, input, CntW, cycle budget latched at run start; 0 disables timeout.
REQ-008 SHALL have port start_o, output, 1, single-cycle start command to OTBN.
REQ-009 SHALL have port busy_i, input, 1, OTBN core busy status.
REQ-010 SHALL have port fetch_addr_i, input, AddrW, current instruction fetch response address.
REQ-011 SHALL have port sample_valid_o, output, 1, single-cycle progress sample strobe.
REQ-012 SHALL have port sample_addr_o, output, AddrW, fetch address captured at sample.
REQ-013 SHALL have port sample_cycle_o, output, CntW, cycle count captured at sample.
REQ-014 SHALL have port cycle_count_o, output, CntW, live run cycle counter.
REQ-015 SHALL have port result_valid_o, output, 1, run finished; result fields stable while high.
REQ-016 SHALL have port result_timeout_o, output, 1, run ended by timeout rather than completion.
REQ-017 SHALL have port result_ack_i, input, 1, consumer acknowledges result.
REQ-018 SHALL have port idle_o, output, 1, controller in IDLE.

Function
REQ-019 SHALL implement states IDLE, START, WAIT_BUSY, RUN, DONE.
REQ-020 IDLE: idle_o=1; run_req_i=1 -> START next cycle, cycle counter cleared to 0, timeout_i latched.
REQ-021 START: start_o=1 for exactly this one cycle; -> WAIT_BUSY unconditionally.
REQ-022 WAIT_BUSY and RUN: cycle counter increments by 1 each cycle, saturating at 2^CntW-1 (no wrap).
REQ-023 WAIT_BUSY: busy_i=1 -> RUN; otherwise remain.
REQ-024 RUN: busy_i=0 -> DONE with result_timeout_o=0.
REQ-025 In WAIT_BUSY or RUN, latched timeout nonzero and counter value after increment equal to it -> DONE with result_timeout_o=1.
REQ-026 Same cycle completion (busy_i=0 in RUN) and timeout: completion wins, result_timeout_o=0.
REQ-027 DONE: result_valid_o=1, counter frozen; result_ack_i=1 -> IDLE next cycle; run_req_i ignored.
REQ-028 Sampler: in RUN, each time counter reaches a nonzero multiple of SampleInterval, sample_valid_o=1 next cycle for one cycle, sample_addr_o=fetch_addr_i and sample_cycle_o=counter captured that cycle.
REQ-029 Sampler SHALL use a down-counter reloaded at run start, no divider; sample fields hold last values between strobes.
REQ-030 No sample strobe in WAIT_BUSY or DONE; a sample due on the cycle RUN exits SHALL still be emitted.
REQ-031 cycle_count_o SHALL always reflect the counter register; result_timeout_o held until next run start.

Reset
REQ-032 On rst_ni=0: state IDLE; start_o, sample_valid_o, result_valid_o, result_timeout_o = 0; counters, sample fields = 0; idle_o=1.
REQ-033 Reset mid-run SHALL abandon the run without start_o or sample_valid_o glitch; first action after release requires a new run_req_i.

Verification
REQ-034 run_req_i pulse, busy_i high 2 cycles after start_o, low after 2500 cycles, timeout 0 -> one start_o, samples at counts 1000 and 2000, result_valid_o=1, result_timeout_o=0.
REQ-035 timeout_i=500, busy_i never falls -> DONE at count 500, result_timeout_o=1, no sample strobe.
REQ-036 timeout_i=1000, busy_i falls exactly at count 1000 -> result_timeout_o=0, sample_cycle_o=1000 strobed once.
REQ-037 run_req_i held high through DONE, result_ack_i delayed 10 cycles -> second start_o only after return to IDLE, counter restarts at 0.
REQ-038 rst_ni low during RUN at count 1500 -> all outputs reset values, idle_o=1, no start_o until next run_req_i.
REQ-039 CntW=8, timeout 0, busy_i held 400 cycles -> cycle_count_o saturates at 255.

Source files
------------

// File: rtl/otbn_run_ctrl.sv
// OTBN run controller: start handshake, cycle counting with timeout,
// periodic progress sampling and result hand-off.
module otbn_run_ctrl #(
  parameter int CntW           = 32,
  parameter int AddrW          = 32,
  parameter int SampleInterval = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_req_i,
  input  logic [CntW-1:0]  timeout_i,
  output logic             start_o,
  input  logic             busy_i,
  input  logic [AddrW-1:0] fetch_addr_i,
  output logic             sample_valid_o,
  output logic [AddrW-1:0] sample_addr_o,
  output logic [CntW-1:0]  sample_cycle_o,
  output logic [CntW-1:0]  cycle_count_o,
  output logic             result_valid_o,
  output logic             result_timeout_o,
  input  logic             result_ack_i,
  output logic             idle_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    RUN,
    DONE
  } state_e;

  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] SiVal  = CntW'(SampleInterval);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  tmo_q, tmo_d;
  logic [CntW-1:0]  sdn_q, sdn_d;
  logic             sv_q, sv_d;
  logic [AddrW-1:0] saddr_q, saddr_d;
  logic [CntW-1:0]  scyc_q, scyc_d;
  logic             rto_q, rto_d;

  logic             at_max;
  logic [CntW-1:0]  cnt_inc;
  logic             tmo_hit;
  logic             tick;

  assign at_max  = (cnt_q == CntMax);
  assign cnt_inc = at_max ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit = (tmo_q != '0) && (cnt_inc == tmo_q);
  // The sampler only advances on a real increment, so a saturated
  // counter never produces further strobes.
  assign tick    = !at_max && (sdn_q == {{(CntW-1){1'b0}}, 1'b1});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      sdn_q   <= '0;
      sv_q    <= 1'b0;
      saddr_q <= '0;
      scyc_q  <= '0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      sdn_q   <= sdn_d;
      sv_q    <= sv_d;
      saddr_q <= saddr_d;
      scyc_q  <= scyc_d;
      rto_q   <= rto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    sdn_d   = sdn_q;
    sv_d    = 1'b0;
    saddr_d = saddr_q;
    scyc_d  = scyc_q;
    rto_d   = rto_q;
    unique case (state_q)
      IDLE: begin
        if (run_req_i) begin
          state_d = START;
          cnt_d   = '0;
          tmo_d   = timeout_i;
          sdn_d   = SiVal;
          rto_d   = 1'b0;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (!at_max) begin
          sdn_d = tick ? SiVal : sdn_q - 1'b1;
        end
        if (tmo_hit) begin
          state_d = DONE;
          rto_d   = 1'b1;
        end else if (busy_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (!at_max) begin
          sdn_d = tick ? SiVal : sdn_q - 1'b1;
        end
        // Capture even on the exit cycle so a due sample is not lost.
        if (tick) begin
          sv_d    = 1'b1;
          saddr_d = fetch_addr_i;
          scyc_d  = cnt_inc;
        end
        if (!busy_i) begin
          state_d = DONE;
          rto_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = DONE;
          rto_d   = 1'b1;
        end
      end
      DONE: begin
        if (result_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign start_o          = (state_q == START);
  assign idle_o           = (state_q == IDLE);
  assign result_valid_o   = (state_q == DONE);
  assign result_timeout_o = rto_q;
  assign cycle_count_o    = cnt_q;
  assign sample_valid_o   = sv_q;
  assign sample_addr_o    = saddr_q;
  assign sample_cycle_o   = scyc_q;

endmodule

// File: tb/tb_otbn_run_ctrl.sv
// Scoreboard bench for otbn_run_ctrl: run scenarios are turned into
// expected start/sample/result events and matched by a monitor.
module tb_otbn_run_ctrl;

  localparam int SI  = 1000;
  localparam int INF = 1 << 30;

  typedef struct {
    int          kind;
    longint      cyc;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic        clk = 0;
  logic        rst_ni = 0;
  logic        run_req = 0;
  logic [31:0] timeout = '0;
  logic        start;
  logic        busy = 0;
  logic [31:0] fetch = '0;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_cycle;
  logic [31:0] cnt;
  logic        r_valid;
  logic        r_to;
  logic        ack = 0;
  logic        idle;

  logic        run8 = 0;
  logic [7:0]  tmo8 = '0;
  logic        start8;
  logic        busy8 = 0;
  logic [31:0] fetch8 = '0;
  logic        sv8;
  logic [31:0] saddr8;
  logic [7:0]  scyc8;
  logic [7:0]  cnt8;
  logic        rv8;
  logic        rto8;
  logic        ack8 = 0;
  logic        idle8;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  ev_t    q[$];
  logic   rv_q = 0;

  int     sq8[$];
  int     nstart8 = 0;
  int     wrap8 = 0;
  logic [7:0] prev8 = '0;

  otbn_run_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .run_req_i       (run_req),
    .timeout_i       (timeout),
    .start_o         (start),
    .busy_i          (busy),
    .fetch_addr_i    (fetch),
    .sample_valid_o  (s_valid),
    .sample_addr_o   (s_addr),
    .sample_cycle_o  (s_cycle),
    .cycle_count_o   (cnt),
    .result_valid_o  (r_valid),
    .result_timeout_o(r_to),
    .result_ack_i    (ack),
    .idle_o          (idle)
  );

  otbn_run_ctrl #(
    .CntW          (8),
    .SampleInterval(100)
  ) dut8 (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .run_req_i       (run8),
    .timeout_i       (tmo8),
    .start_o         (start8),
    .busy_i          (busy8),
    .fetch_addr_i    (fetch8),
    .sample_valid_o  (sv8),
    .sample_addr_o   (saddr8),
    .sample_cycle_o  (scyc8),
    .cycle_count_o   (cnt8),
    .result_valid_o  (rv8),
    .result_timeout_o(rto8),
    .result_ack_i    (ack8),
    .idle_o          (idle8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] a,
                         input logic [31:0] b);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d a=%h b=%h, required none",
               kind, cyc, a, b);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d a=%h b=%h, required kind=%0d cyc=%0d a=%h b=%h",
                 kind, cyc, a, b, e.kind, e.cyc, e.a, e.b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      rv_q = 1'b0;
    end else begin
      if (start) observe(0, 32'd0, cnt);
      if (s_valid) observe(1, s_addr, s_cycle);
      if (r_valid && !rv_q) observe(2, {31'd0, r_to}, cnt);
      rv_q = r_valid;
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      if (sv8) sq8.push_back(int'(scyc8));
      if (start8) nstart8++;
      if (cnt8 < prev8 && !start8) wrap8++;
      prev8 = cnt8;
    end
  end

  function automatic void push(int kind, longint c, logic [31:0] a,
                               logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.a    = a;
    e.b    = b;
    q.push_back(e);
  endfunction

  // Called at #1 into an IDLE cycle. Cycle t counts from the START
  // cycle (t=0); busy is high for b <= t < e (e<0: never falls).
  task automatic run(input int b, input int e, input int tmo,
                     input int ackd, input bit hold, input int rst_at);
    longint      c0;
    int          ce, endc, lim;
    bit          to;
    logic [31:0] base;
    base    = $urandom;
    run_req = 1;
    timeout = 32'(tmo);
    c0      = cyc;
    ce      = (e < 0) ? INF : ((e > b + 1) ? e : b + 1);
    if (tmo != 0 && tmo <= b) begin
      endc = tmo;
      to   = 1;
    end else if (tmo != 0 && tmo < ce) begin
      endc = tmo;
      to   = 1;
    end else begin
      endc = ce;
      to   = 0;
    end
    push(0, c0 + 1, 32'd0, 32'd0);
    for (int k = SI; k <= endc && (rst_at == 0 || k < rst_at); k += SI) begin
      if (k >= b + 1 && (rst_at == 0 || k + 1 < rst_at))
        push(1, c0 + 2 + k, base + 32'(4 * k), 32'(k));
    end
    if (rst_at == 0) push(2, c0 + 2 + endc, {31'd0, to}, 32'(endc));
    lim = (rst_at != 0) ? rst_at : endc + 1;
    @(posedge clk); #1;
    if (!hold) run_req = 0;
    busy  = 0;
    fetch = base;
    for (int t = 1; t <= lim; t++) begin
      @(posedge clk); #1;
      busy  = (t < lim) && t >= b && (e < 0 || t < e);
      fetch = base + 32'(4 * t);
    end
    if (rst_at != 0) begin
      rst_ni  = 0;
      run_req = 0;
      busy    = 0;
      #1;
      chk("rst_start", {63'd0, start}, 64'd0);
      chk("rst_sample_valid", {63'd0, s_valid}, 64'd0);
      chk("rst_result_valid", {63'd0, r_valid}, 64'd0);
      chk("rst_result_timeout", {63'd0, r_to}, 64'd0);
      chk("rst_count", {32'd0, cnt}, 64'd0);
      chk("rst_sample_addr", {32'd0, s_addr}, 64'd0);
      chk("rst_sample_cycle", {32'd0, s_cycle}, 64'd0);
      chk("rst_idle", {63'd0, idle}, 64'd1);
      repeat (3) @(posedge clk);
      #1 rst_ni = 1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_rst_idle", {63'd0, idle}, 64'd1);
      chk("post_rst_queue", 64'(q.size()), 64'd0);
    end else begin
      repeat (ackd) begin
        @(posedge clk); #1;
      end
      chk("done_valid", {63'd0, r_valid}, 64'd1);
      chk("done_count", {32'd0, cnt}, 64'(endc));
      chk("done_timeout", {63'd0, r_to}, {63'd0, to});
      ack = 1;
      @(posedge clk); #1;
      ack = 0;
      chk("ack_idle", {63'd0, idle}, 64'd1);
      chk("ack_timeout_held", {63'd0, r_to}, {63'd0, to});
    end
  endtask

  initial begin
    int b, e, tmo, mode;
    #12;
    chk("reset_idle", {63'd0, idle}, 64'd1);
    chk("reset_start", {63'd0, start}, 64'd0);
    chk("reset_result", {63'd0, r_valid}, 64'd0);
    chk("reset_count", {32'd0, cnt}, 64'd0);
    @(posedge clk); #1;
    rst_ni = 1;
    repeat (2) @(posedge clk);
    #1;

    run(2, 2502, 0, 0, 0, 0);
    run(2, -1, 500, 3, 0, 0);
    run(2, 1000, 1000, 1, 0, 0);
    run(3, 300, 0, 10, 1, 0);
    run(2, 50, 0, 0, 0, 0);
    run(2, -1, 0, 0, 0, 1501);

    for (int i = 0; i < 8; i++) begin
      b    = $urandom_range(1, 5);
      mode = $urandom_range(0, 3);
      e    = b + $urandom_range(1, 2600);
      case (mode)
        0: tmo = 0;
        1: tmo = $urandom_range(1, 6);
        2: tmo = $urandom_range(b + 1, 2600);
        default: begin
          tmo = $urandom_range(b + 1, 2600);
          e   = tmo;
        end
      endcase
      run(b, e, tmo, $urandom_range(0, 6), bit'($urandom_range(0, 1)), 0);
    end
    run_req = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);

    run8 = 1;
    @(posedge clk); #1;
    run8 = 0;
    for (int t = 1; t <= 405; t++) begin
      @(posedge clk); #1;
      busy8 = (t >= 2 && t < 402);
    end
    chk("sat_result_valid", {63'd0, rv8}, 64'd1);
    chk("sat_count", {56'd0, cnt8}, 64'd255);
    chk("sat_timeout", {63'd0, rto8}, 64'd0);
    chk("sat_no_wrap", 64'(wrap8), 64'd0);
    chk("sat_starts", 64'(nstart8), 64'd1);
    chk("sat_samples", 64'(sq8.size()), 64'd2);
    if (sq8.size() == 2) begin
      chk("sat_sample0", 64'(sq8[0]), 64'd100);
      chk("sat_sample1", 64'(sq8[1]), 64'd200);
    end
    ack8 = 1;
    @(posedge clk); #1;
    ack8 = 0;
    chk("sat_idle", {63'd0, idle8}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
